// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: fetch at pc, hand ir downstream, then pulse one pc command.
// Optional FETCH_TIMEOUT_EN adds a mem_ack watchdog that faults and halts.
module fetch_seq #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] pc,
  output logic          inc,
  output logic          add,
  output logic          sub,
  output logic [AW-1:0] offset,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] ir,
  output logic          ir_valid,
  input  logic          ir_ready,
  output logic          halted,
  output logic          fault
);

  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, UPDATE, HALT} state_t;
  state_t state;

  // Address follows pc combinationally so a pc update lands on the very next request.
  assign mem_addr = mem_req ? pc : '0;

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] tcnt;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      mem_req  <= 1'b0;
      ir       <= '0;
      ir_valid <= 1'b0;
      inc      <= 1'b0;
      add      <= 1'b0;
      sub      <= 1'b0;
      offset   <= '0;
      halted   <= 1'b0;
      fault    <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      tcnt     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          state   <= FETCH;
          mem_req <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
          tcnt    <= '0;
`endif
        end
        FETCH: begin
          if (mem_ack) begin
            ir       <= mem_rdata;
            mem_req  <= 1'b0;
            ir_valid <= 1'b1;
            state    <= ISSUE;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (tcnt == TLAST) begin
            mem_req <= 1'b0;
            fault   <= 1'b1;
            halted  <= 1'b1;
            state   <= HALT;
          end else begin
            tcnt <= tcnt + CW'(1);
          end
`endif
        end
        ISSUE: begin
          if (ir_ready) begin
            ir_valid <= 1'b0;
            state    <= UPDATE;
            // Displacement is always zero-extended; add/sub alone sets direction.
            case (ir[15:12])
              4'hE: begin
                add    <= 1'b1;
                offset <= {{(AW-8){1'b0}}, ir[7:0]};
              end
              4'hF: begin
                sub    <= 1'b1;
                offset <= {{(AW-8){1'b0}}, ir[7:0]};
              end
              default: inc <= (ir != '0);
            endcase
          end
        end
        UPDATE: begin
          inc    <= 1'b0;
          add    <= 1'b0;
          sub    <= 1'b0;
          offset <= '0;
          if (ir == '0) begin
            halted <= 1'b1;
            state  <= HALT;
          end else begin
            mem_req <= 1'b1;
            state   <= FETCH;
`ifdef FETCH_TIMEOUT_EN
            tcnt    <= '0;
`endif
          end
        end
        HALT: begin
          halted <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: a tiny pc register reacts to inc/add/sub, memory is driven by hand.
module tb_fetch_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] pc;
  logic        inc, add, sub;
  logic [15:0] offset;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
  logic [15:0] ir;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic        halted, fault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_seq #(.AW(16), .DW(16), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .pc(pc),
    .inc(inc), .add(add), .sub(sub), .offset(offset),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ir(ir), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .halted(halted), .fault(fault)
  );

  // Stand-in for the pc block.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   pc <= 16'h0000;
    else if (inc) pc <= pc + 16'h0001;
    else if (add) pc <= pc + offset;
    else if (sub) pc <= pc - offset;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [15:0] rdata;
    logic        e_inc, e_add, e_sub;
    logic [15:0] e_off;
    logic [15:0] nxt;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{16'h0000, 16'h1234, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0001};
    tbl[1] = '{16'h0001, 16'hE00F, 1'b0, 1'b1, 1'b0, 16'h000F, 16'h0010};
    tbl[2] = '{16'h0010, 16'hE0A5, 1'b0, 1'b1, 1'b0, 16'h00A5, 16'h00B5};
    tbl[3] = '{16'h00B5, 16'hF014, 1'b0, 1'b0, 1'b1, 16'h0014, 16'h00A1};
    tbl[4] = '{16'h00A1, 16'hE700, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h00A1};
    tbl[5] = '{16'h00A1, 16'hFFFF, 1'b0, 1'b0, 1'b1, 16'h00FF, 16'hFFA2};
    tbl[6] = '{16'hFFA2, 16'hE0FF, 1'b0, 1'b1, 1'b0, 16'h00FF, 16'h00A1};
    tbl[7] = '{16'h00A1, 16'hDFFF, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h00A2};
    tbl[8] = '{16'h00A2, 16'h0001, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h00A3};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_ir", ir, 0);
    chk("rst_cmds", {inc, add, sub, ir_valid, halted, fault}, 0);
    reset = 1'b1;
    chk("idle_no_req", mem_req, 0);
    @(negedge clk);
    chk("first_req", mem_req, 1);
    chk("first_addr", mem_addr, 16'h0000);

    // Zero-wait memory, ir_ready tied high
    foreach (tbl[i]) begin
      chk("fetch_req", mem_req, 1);
      chk("fetch_addr", mem_addr, tbl[i].addr);
      mem_ack = 1'b1; mem_rdata = tbl[i].rdata; ir_ready = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = 16'h5555;
      chk("issue_ir", ir, tbl[i].rdata);
      chk("issue_valid", ir_valid, 1);
      chk("issue_no_req", mem_req, 0);
      @(negedge clk);
      chk("upd_cmd", {inc, add, sub}, {tbl[i].e_inc, tbl[i].e_add, tbl[i].e_sub});
      chk("upd_offset", offset, tbl[i].e_off);
      chk("upd_valid_low", ir_valid, 0);
      @(negedge clk);
      chk("next_addr", mem_addr, tbl[i].nxt);
      chk("cmd_one_cycle", {inc, add, sub}, 0);
    end

    // Downstream stall: ir stable, no command until ready
    mem_ack = 1'b1; mem_rdata = 16'h1234; ir_ready = 1'b0;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 16'h9999;
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", ir_valid, 1);
      chk("stall_ir", ir, 16'h1234);
      chk("stall_no_cmd", {inc, add, sub}, 0);
      @(negedge clk);
    end
    ir_ready = 1'b1;
    @(negedge clk);
    chk("stall_inc", inc, 1);
    @(negedge clk);
    chk("stall_next", mem_addr, 16'h00A4);

    // Slow memory with junk data, then ack together with ready
    ir_ready = 1'b0; mem_rdata = 16'hDEAD;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("wait_req", mem_req, 1);
      chk("wait_addr", mem_addr, 16'h00A4);
      chk("wait_no_valid", ir_valid, 0);
    end
    mem_ack = 1'b1; mem_rdata = 16'h2222; ir_ready = 1'b1;
    @(negedge clk);
    chk("late_ir", ir, 16'h2222);
    chk("late_valid", ir_valid, 1);
    mem_rdata = 16'hBEEF; ir_ready = 1'b0;
    @(negedge clk);
    chk("ready_in_fetch_ignored", ir_valid, 1);
    chk("ack_outside_fetch", ir, 16'h2222);
    ir_ready = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("late_inc", inc, 1);
    chk("late_ir_hold", ir, 16'h2222);
    @(negedge clk);
    chk("late_next", mem_addr, 16'h00A5);

    // Asynchronous reset in the middle of FETCH
    chk("pre_rst_req", mem_req, 1);
    reset = 1'b0;
    #1;
    chk("arst_req", mem_req, 0);
    chk("arst_addr", mem_addr, 0);
    chk("arst_ir", ir, 0);
    chk("arst_outs", {inc, add, sub, ir_valid, halted, fault}, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rerun_req", mem_req, 1);
    chk("rerun_addr", mem_addr, 16'h0000);

    // Zero instruction halts
    mem_ack = 1'b1; mem_rdata = 16'h0000; ir_ready = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("halt_issue_valid", ir_valid, 1);
    @(negedge clk);
    chk("halt_no_cmd", {inc, add, sub}, 0);
    chk("halt_valid_low", ir_valid, 0);
    @(negedge clk);
    chk("halted", halted, 1);
    mem_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("halt_no_req", mem_req, 0);
      chk("halt_stays", {halted, ir_valid, inc, add, sub}, 5'b10000);
    end
    mem_ack = 1'b0;

    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_halt_req", mem_req, 1);
    chk("post_halt_clear", halted, 0);

`ifdef FETCH_TIMEOUT_EN
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("to_wait_req", mem_req, 1);
      chk("to_wait_fault", fault, 0);
    end
    @(negedge clk);
    chk("to_fault", fault, 1);
    chk("to_halted", halted, 1);
    chk("to_req_drop", mem_req, 0);
    @(negedge clk);
    chk("to_sticky", fault, 1);
`else
    repeat (20) @(negedge clk);
    chk("forever_req", mem_req, 1);
    chk("forever_no_fault", {fault, halted}, 0);
    mem_ack = 1'b1; mem_rdata = 16'h4321;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("forever_capture", ir, 16'h4321);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
